// File: rtl/noc_pkg.sv
// noc_pkg: shared flit-width constants, flit type and route-digit extraction helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 24
`endif

package noc_pkg;
    localparam int NOC_ADDR_W = `ADDR_WIDTH;
    localparam int NOC_DATA_W = `DATA_WIDTH;
    localparam int NOC_WIDTH  = NOC_ADDR_W + NOC_DATA_W;
    // Widest flit the route helper accepts; callers zero-extend into it.
    localparam int NOC_MAX_W  = 256;

    typedef logic [NOC_WIDTH-1:0] flit_t;

    // Route digit = rw bits of the flit starting at bit lsb, returned zero-extended.
    function automatic logic [31:0] route_digit(input logic [NOC_MAX_W-1:0] flit,
                                                input int lsb, input int rw);
        logic [NOC_MAX_W-1:0] mask;
        mask = (NOC_MAX_W'(1) << rw) - NOC_MAX_W'(1);
        return 32'((flit >> lsb) & mask);
    endfunction
endpackage

// File: rtl/noc_input_fifo.sv
// noc_input_fifo: shift-register flit queue, head always presented at slot 0.
// Latency: a flit written at edge k is visible on o_head right after edge k.
// Backpressure: o_full while DEPTH flits are held; i_enq is ignored while full.
module noc_input_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             i_enq,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_deq,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_slot [DEPTH];
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_slot_nxt [DEPTH];
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;

    assign o_empty  = (r_cnt == '0);
    assign o_full   = (r_cnt == CW'(DEPTH));
    assign o_head   = r_slot[0];
    assign w_push   = i_enq & ~o_full;
    assign w_pop    = i_deq & ~o_empty;
    // Write lands just behind the last flit that survives this edge.
    assign w_wr_idx = AW'(w_pop ? (r_cnt - CW'(1)) : r_cnt);

    // Next slot contents: shift toward slot 0 on pop, then place the new flit.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_slot_nxt[k] = r_slot[k];
        end
        if (w_pop) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                w_slot_nxt[k] = r_slot[k + 1];
            end
            w_slot_nxt[DEPTH-1] = '0;
        end
        if (w_push) begin
            w_slot_nxt[w_wr_idx] = i_dat;
        end
    end

    // Slot and occupancy registers; reset empties the queue and clears storage.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= '0;
            end
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= w_slot_nxt[k];
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/noc_router_node.sv
// noc_router_node: per-input FIFOs routed by a head route digit to RADIX_OUT outputs; NOC_RR_ARB_EN selects round-robin, else fixed priority.
// Latency: one edge minimum (flit written at edge k is offered after k, transfers at k+1).
// Backpressure: FIFO_FULL per input; output o offers nothing while FIFO_FULL_downstream[o] is set.
module noc_router_node
    import noc_pkg::*;
#(
    parameter int RADIX_IN  = 2,
    parameter int RADIX_OUT = 2,
    parameter int WIDTH     = `ADDR_WIDTH + `DATA_WIDTH,
    parameter int DEPTH     = 4,
    parameter int ROUTE_LSB = WIDTH - 6
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [RADIX_IN-1:0]  FIFO_ENQ,
    input  logic [WIDTH-1:0]     FIFO_IN [RADIX_IN],
    output logic [RADIX_IN-1:0]  FIFO_FULL,
    output logic [RADIX_OUT-1:0] FIFO_ENQ_downstream,
    output logic [WIDTH-1:0]     FIFO_OUT [RADIX_OUT],
    input  logic [RADIX_OUT-1:0] FIFO_FULL_downstream
);
    localparam int RW = $clog2(RADIX_OUT);
    localparam int PW = (RADIX_IN > 1) ? $clog2(RADIX_IN) : 1;

    logic [WIDTH-1:0]     w_head [RADIX_IN];
    logic [RADIX_IN-1:0]  w_empty;
    logic [RADIX_IN-1:0]  w_deq;
    logic [31:0]          w_dig [RADIX_IN];
    logic [RADIX_OUT-1:0] w_gnt_vld;
    logic [PW-1:0]        w_gnt_idx [RADIX_OUT];

`ifdef NOC_RR_ARB_EN
    logic [PW-1:0]        r_ptr [RADIX_OUT];
`endif

    for (genvar g = 0; g < RADIX_IN; g++) begin : g_in
        noc_input_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_l   (rst_l),
            .i_enq   (FIFO_ENQ[g]),
            .i_dat   (FIFO_IN[g]),
            .i_deq   (w_deq[g]),
            .o_head  (w_head[g]),
            .o_empty (w_empty[g]),
            .o_full  (FIFO_FULL[g])
        );
        assign w_dig[g] = route_digit(NOC_MAX_W'(w_head[g]), ROUTE_LSB, RW);
    end

    // Per-output arbitration among non-empty heads whose digit names that output;
    // heads with an out-of-range digit are dropped without any downstream strobe.
    always_comb begin
        logic [PW-1:0] v_sel;
        v_sel     = '0;
        w_gnt_vld = '0;
        w_deq     = '0;
        for (int o = 0; o < RADIX_OUT; o++) begin
            w_gnt_idx[o] = '0;
        end
        for (int o = 0; o < RADIX_OUT; o++) begin
            if (!FIFO_FULL_downstream[o]) begin
                for (int k = 0; k < RADIX_IN; k++) begin
`ifdef NOC_RR_ARB_EN
                    v_sel = PW'((int'(r_ptr[o]) + k) % RADIX_IN);
`else
                    v_sel = PW'(k);
`endif
                    if (!w_gnt_vld[o] && !w_empty[v_sel] && (w_dig[v_sel] == 32'(o))) begin
                        w_gnt_vld[o] = 1'b1;
                        w_gnt_idx[o] = v_sel;
                    end
                end
            end
        end
        for (int i = 0; i < RADIX_IN; i++) begin
            if (!w_empty[i] && (w_dig[i] >= 32'(RADIX_OUT))) begin
                w_deq[i] = 1'b1;
            end
        end
        for (int o = 0; o < RADIX_OUT; o++) begin
            if (w_gnt_vld[o]) begin
                w_deq[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    // Downstream strobe and data; idle outputs drive all-zero data.
    always_comb begin
        FIFO_ENQ_downstream = w_gnt_vld;
        for (int o = 0; o < RADIX_OUT; o++) begin
            FIFO_OUT[o] = w_gnt_vld[o] ? w_head[w_gnt_idx[o]] : '0;
        end
    end

`ifdef NOC_RR_ARB_EN
    // Round-robin pointers: next search starts just past the last granted input.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int o = 0; o < RADIX_OUT; o++) begin
                r_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < RADIX_OUT; o++) begin
                if (w_gnt_vld[o]) begin
                    r_ptr[o] <= PW'((int'(w_gnt_idx[o]) + 1) % RADIX_IN);
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_noc_router_node.sv
// tb_noc_router_node: queue-model scoreboard plus directed scenarios for noc_router_node.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_noc_router_node;
    import noc_pkg::*;

    localparam int NI  = 2;
    localparam int NO  = 2;
    localparam int DEP = 4;
    localparam int LSB = NOC_WIDTH - 6;

    logic          clk;
    logic          rst_l;
    logic [NI-1:0] enq;
    flit_t         fin [NI];
    logic [NI-1:0] full;
    logic [NO-1:0] enq_ds;
    flit_t         fout [NO];
    logic [NO-1:0] ds_full;

    logic [1:0]    enq3;
    flit_t         fin3 [2];
    logic [1:0]    full3;
    logic [2:0]    enq_ds3;
    flit_t         fout3 [3];
    logic [2:0]    dsf3;

    int checks = 0;
    int errors = 0;
    int exp_ord [6];

    // Reference model state: one queue per input, plus round-robin pointers.
    flit_t mq [NI][$];
    int    mptr [NO];

    logic [NO-1:0]              u_xe;
    logic [NO-1:0][NOC_WIDTH-1:0] u_xo;
    logic [NI-1:0]              u_xd;
    logic [NO-1:0][7:0]         u_xg;
    logic [NI-1:0]              u_fb;

    logic [NO-1:0]              c_xe;
    logic [NO-1:0][NOC_WIDTH-1:0] c_xo;
    logic [NI-1:0]              c_xd;
    logic [NO-1:0][7:0]         c_xg;
    logic [NI-1:0]              c_ef;

    noc_router_node u_dut (
        .clk                  (clk),
        .rst_l                (rst_l),
        .FIFO_ENQ             (enq),
        .FIFO_IN              (fin),
        .FIFO_FULL            (full),
        .FIFO_ENQ_downstream  (enq_ds),
        .FIFO_OUT             (fout),
        .FIFO_FULL_downstream (ds_full)
    );

    noc_router_node #(.RADIX_OUT(3)) u_dut3 (
        .clk                  (clk),
        .rst_l                (rst_l),
        .FIFO_ENQ             (enq3),
        .FIFO_IN              (fin3),
        .FIFO_FULL            (full3),
        .FIFO_ENQ_downstream  (enq_ds3),
        .FIFO_OUT             (fout3),
        .FIFO_FULL_downstream (dsf3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic flit_t mk(input int d, input int pay);
        flit_t m;
        m = (flit_t'(1) << LSB) - flit_t'(1);
        return (flit_t'(d) << LSB) | (flit_t'(pay) & m);
    endfunction

    function automatic int dig(input flit_t f);
        return int'(f[LSB]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // What the outputs must be given the queued flits and current downstream full.
    task automatic model_eval(output logic [NO-1:0] xe, output logic [NO-1:0][NOC_WIDTH-1:0] xo,
                              output logic [NI-1:0] xd, output logic [NO-1:0][7:0] xg);
        int i;
        xe = '0;
        xo = '0;
        xd = '0;
        xg = '0;
        for (int o = 0; o < NO; o++) begin
            if (!ds_full[o]) begin
                for (int k = 0; k < NI; k++) begin
`ifdef NOC_RR_ARB_EN
                    i = (mptr[o] + k) % NI;
`else
                    i = k;
`endif
                    if (!xe[o] && (mq[i].size() != 0)) begin
                        if (dig(mq[i][0]) == o) begin
                            xe[o] = 1'b1;
                            xo[o] = mq[i][0];
                            xd[i] = 1'b1;
                            xg[o] = 8'(i);
                        end
                    end
                end
            end
        end
    endtask

    // Model update on each edge; reset discards everything.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NI; i++) mq[i].delete();
            for (int o = 0; o < NO; o++) mptr[o] = 0;
        end else begin
            model_eval(u_xe, u_xo, u_xd, u_xg);
            for (int i = 0; i < NI; i++) u_fb[i] = (mq[i].size() == DEP);
`ifdef NOC_RR_ARB_EN
            for (int o = 0; o < NO; o++) if (u_xe[o]) mptr[o] = (int'(u_xg[o]) + 1) % NI;
`endif
            for (int i = 0; i < NI; i++) if (u_xd[i]) void'(mq[i].pop_front());
            for (int i = 0; i < NI; i++) if (enq[i] && !u_fb[i]) mq[i].push_back(fin[i]);
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        model_eval(c_xe, c_xo, c_xd, c_xg);
        for (int i = 0; i < NI; i++) c_ef[i] = (mq[i].size() == DEP);
        chk("mdl_full", 32'(full), 32'(c_ef));
        chk("mdl_enq_ds", 32'(enq_ds), 32'(c_xe));
        chk("mdl_out0", 32'(fout[0]), 32'(c_xo[0]));
        chk("mdl_out1", 32'(fout[1]), 32'(c_xo[1]));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
    endtask

    initial begin
`ifdef NOC_RR_ARB_EN
        exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0;
        exp_ord[3] = 1; exp_ord[4] = 0; exp_ord[5] = 1;
`else
        exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 0;
        exp_ord[3] = 1; exp_ord[4] = 1; exp_ord[5] = 1;
`endif
        rst_l = 1'b0; enq = '0; ds_full = '0; fin[0] = '0; fin[1] = '0;
        enq3 = '0; fin3[0] = '0; fin3[1] = '0; dsf3 = '0;
        step(); step();
        peek();
        chk("in_reset_enq_ds", 32'(enq_ds), 32'h0);
        chk("in_reset_full", 32'(full), 32'h0);
        step(); rst_l = 1'b1;

        // Reset state, no enqueues.
        peek();
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_enq_ds", 32'(enq_ds), 32'h0);
        chk("rst_out0", 32'(fout[0]), 32'h0);
        chk("rst_out1", 32'(fout[1]), 32'h0);
        chk("rst_enq_ds3", 32'(enq_ds3), 32'h0);

        // Single flit input0 -> output1, one-edge latency, one-cycle strobe.
        step(); fin[0] = mk(1, 'h11); enq = 2'b01;
        step(); enq = 2'b00;
        peek();
        chk("single_enq_ds", 32'(enq_ds), 32'h2);
        chk("single_out1", 32'(fout[1]), 32'(mk(1, 'h11)));
        chk("single_out0", 32'(fout[0]), 32'h0);
        step(); peek();
        chk("single_after", 32'(enq_ds), 32'h0);

        // Backpressure: five flits into a depth-4 FIFO with both outputs blocked.
        step(); ds_full = 2'b11;
        for (int n = 0; n < 5; n++) begin
            fin[0] = mk(0, 'hA0 + n); enq = 2'b01;
            @(posedge clk); #1; enq = 2'b00;
            peek();
            chk("bp_full", 32'(full), (n >= 3) ? 32'h1 : 32'h0);
            chk("bp_enq_ds", 32'(enq_ds), 32'h0);
        end
        step(); ds_full = 2'b00;
        for (int m = 0; m < 4; m++) begin
            peek();
            chk("bp_drain_enq_ds", 32'(enq_ds), 32'h1);
            chk("bp_drain_out0", 32'(fout[0]), 32'(mk(0, 'hA0 + m)));
            step();
        end
        peek();
        chk("bp_e_dropped", 32'(enq_ds), 32'h0);
        chk("bp_full_clear", 32'(full), 32'h0);

        // Contention: both inputs hold 3 flits for output 0; pointers freshly reset.
        step(); rst_l = 1'b0;
        step(); rst_l = 1'b1; ds_full = 2'b11;
        for (int n = 0; n < 3; n++) begin
            fin[0] = mk(0, 'h100 + n); fin[1] = mk(0, 'h200 + n); enq = 2'b11;
            step();
        end
        enq = 2'b00; ds_full = 2'b00;
        for (int g = 0; g < 6; g++) begin
            peek();
            chk("arb_enq_ds0", 32'(enq_ds[0]), 32'h1);
            chk("arb_order", 32'(int'(fout[0][11:8]) - 1), 32'(exp_ord[g]));
            step();
        end
        peek();
        chk("arb_idle", 32'(enq_ds), 32'h0);

        // Parallel: input0 -> out1 and input1 -> out0 in the same cycle.
        step(); fin[0] = mk(1, 'h301); fin[1] = mk(0, 'h302); enq = 2'b11;
        step(); enq = 2'b00;
        peek();
        chk("par_enq_ds", 32'(enq_ds), 32'h3);
        chk("par_out0", 32'(fout[0]), 32'(mk(0, 'h302)));
        chk("par_out1", 32'(fout[1]), 32'(mk(1, 'h301)));
        step(); peek();
        chk("par_after", 32'(enq_ds), 32'h0);

        // Invalid digit 3 with three outputs: discarded, valid flit behind it proceeds.
        step(); fin3[0] = mk(3, 'h333); enq3 = 2'b01;
        @(posedge clk); #1; fin3[0] = mk(2, 'h334);
        peek();
        chk("inv_enq_ds3", 32'(enq_ds3), 32'h0);
        chk("inv_out3_0", 32'(fout3[0]), 32'h0);
        chk("inv_out3_1", 32'(fout3[1]), 32'h0);
        chk("inv_out3_2", 32'(fout3[2]), 32'h0);
        @(posedge clk); #1; enq3 = 2'b00;
        peek();
        chk("inv_next_enq_ds3", 32'(enq_ds3), 32'h4);
        chk("inv_next_out3_2", 32'(fout3[2]), 32'(mk(2, 'h334)));
        step(); peek();
        chk("inv_idle3", 32'(enq_ds3), 32'h0);
        chk("inv_full3", 32'(full3), 32'h0);

        // Reset mid-operation: queued flits are lost, outputs drop at once.
        step(); ds_full = 2'b11;
        for (int n = 0; n < 3; n++) begin
            fin[0] = mk(1, 'h401 + n); enq = 2'b01;
            step();
        end
        enq = 2'b00; ds_full = 2'b00;
        #1;
        chk("mid_pre_enq_ds", 32'(enq_ds), 32'h2);
        chk("mid_pre_out1", 32'(fout[1]), 32'(mk(1, 'h401)));
        #1; rst_l = 1'b0;
        #1;
        chk("mid_rst_enq_ds", 32'(enq_ds), 32'h0);
        chk("mid_rst_out0", 32'(fout[0]), 32'h0);
        chk("mid_rst_out1", 32'(fout[1]), 32'h0);
        chk("mid_rst_full", 32'(full), 32'h0);
        step(); step(); rst_l = 1'b1;
        for (int m = 0; m < 4; m++) begin
            peek();
            chk("mid_post_enq_ds", 32'(enq_ds), 32'h0);
            chk("mid_post_out1", 32'(fout[1]), 32'h0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_router_node.md
NOC_ROUTER_NODE -- requirements
Module: noc_router_node

Interface
REQ-001 SHALL have parameter RADIX_IN, default 2: number of input ports.
REQ-002 SHALL have parameter RADIX_OUT, default 2: number of output ports, >=2.
REQ-003 SHALL have parameter WIDTH, default `ADDR_WIDTH+`DATA_WIDTH: flit width in bits.
REQ-004 SHALL have parameter DEPTH, default 4: per-input FIFO depth, >=2.
REQ-005 SHALL have parameter ROUTE_LSB, default WIDTH-6: LSB of the route digit; digit width RW = $clog2(RADIX_OUT).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_l, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port FIFO_ENQ, input, [RADIX_IN]: per-input enqueue strobe.
REQ-009 SHALL have port FIFO_IN, input, [RADIX_IN][WIDTH]: per-input flit.
REQ-010 SHALL have port FIFO_FULL, output, [RADIX_IN]: per-input FIFO full.
REQ-011 SHALL have port FIFO_ENQ_downstream, output, [RADIX_OUT]: per-output enqueue strobe.
REQ-012 SHALL have port FIFO_OUT, output, [RADIX_OUT][WIDTH]: per-output flit.
REQ-013 SHALL have port FIFO_FULL_downstream, input, [RADIX_OUT]: per-output downstream full.

Function
REQ-014 SHALL write FIFO_IN[i] into input FIFO i at a rising edge where FIFO_ENQ[i]=1 and FIFO_FULL[i]=0.
REQ-015 SHALL ignore FIFO_ENQ[i] while FIFO_FULL[i]=1: contents and count unchanged.
REQ-016 SHALL drive FIFO_FULL[i]=1 exactly when the count of FIFO i equals DEPTH (registered-state decode).
REQ-017 SHALL make a non-empty FIFO i request output d = FIFO_IN-format head bits [ROUTE_LSB+RW-1:ROUTE_LSB].
REQ-018 SHALL treat an output o as eligible only while FIFO_FULL_downstream[o]=0 in the same cycle.
REQ-019 SHALL grant at most one input per eligible output per cycle; one input is granted at most one output.
REQ-020 SHALL drive FIFO_ENQ_downstream[o]=1 and FIFO_OUT[o]=granted head combinationally from state and FIFO_FULL_downstream; otherwise ENQ 0 and FIFO_OUT all-zero.
REQ-021 SHALL dequeue the granted head at the next rising edge; flits leave each FIFO in arrival order.
REQ-022 SHALL allow enqueue and dequeue of one FIFO at the same edge when not full; count unchanged.
REQ-023 SHALL give minimum latency one edge: flit written at edge k appears on FIFO_OUT after edge k and transfers at edge k+1.
REQ-024 SHALL discard a head whose digit >= RADIX_OUT: dequeued at the next edge, no downstream ENQ.
REQ-025 SHALL transfer on different outputs in parallel within one cycle with no interaction.

Reset
REQ-026 SHALL, on rst_l=0, asynchronously empty all FIFOs, zero storage, reset arbitration pointers to 0.
REQ-027 SHALL hold FIFO_FULL=0, FIFO_ENQ_downstream=0, FIFO_OUT=0 while and after reset until new enqueues; reset mid-transfer discards all queued flits.

Configuration
REQ-028 SHALL, with macro NOC_RR_ARB_EN defined, arbitrate each output round-robin: search from pointer p[o]; after grant to input i, p[o]=(i+1) mod RADIX_IN; p[o] unchanged when no grant.
REQ-029 SHALL, without NOC_RR_ARB_EN, arbitrate fixed priority (lowest input index wins) and contain no pointer state.

Structure
REQ-030 SHALL place WIDTH default constants, flit typedef and route-digit extraction function in shared package noc_pkg.
REQ-031 SHALL instantiate one sub-module noc_input_fifo (shift-register FIFO, head at slot 0) per input; arbitration SHALL be inline.

Verification
REQ-032 SHALL cover reset: rst_l low then high, no ENQ -> FIFO_FULL=00, FIFO_ENQ_downstream=00, FIFO_OUT all-zero.
REQ-033 SHALL cover single flit: input0 digit 1, downstream 00 -> FIFO_ENQ_downstream=10 for exactly one cycle after enqueue edge, FIFO_OUT[1]=flit.
REQ-034 SHALL cover backpressure: downstream 11, enqueue 5 flits A..E on input0 -> FIFO_FULL[0]=1 after 4th edge, E dropped; downstream 00 -> A,B,C,D out on 4 consecutive cycles.
REQ-035 SHALL cover contention: inputs 0 and 1 each hold 3 flits to output 0 -> RR grants 0,1,0,1,0,1; fixed priority 0,0,0,1,1,1.
REQ-036 SHALL cover parallel and invalid: input0->out1 and input1->out0 transfer in the same cycle; with RADIX_OUT=3, digit 3 -> flit discarded, no ENQ.
REQ-037 SHALL cover reset mid-operation: 3 flits queued, rst_l pulsed low -> outputs 0 immediately, no queued flit appears afterwards.
